// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the digit-serial carry-save resolver.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Number of digit cycles per operation.
  function automatic int unsigned num_digits(input int unsigned w, input int unsigned d);
    return w / d;
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/csa_digit_add.sv
// One DIGIT-wide ripple of full adders; purely combinational.
module csa_digit_add #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  // Ripple the carry through the digit, LSB first.
  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/csa_resolve_serial.sv
// Digit-serial carry-propagate stage: resolves {sum, carry} into binary, DIGIT bits per clock.
module csa_resolve_serial
  import csa_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_sum,
  input  logic [W-1:0] in_carry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_result
);

  localparam int unsigned N  = num_digits(W, DIGIT);
  localparam int unsigned CW = cnt_width(N);

  // Reject digit sizes that do not tile the operand exactly.
  if ((DIGIT < 1) || (DIGIT > W) || ((W % DIGIT) != 0)) begin : g_bad_digit
    $error("csa_resolve_serial: DIGIT must be in 1..W and divide W");
  end

  state_t           state_q;
  logic [W-1:0]     sum_q;
  logic [W-1:0]     car_q;
  logic [W:0]       res_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;

  csa_digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a    (sum_q[DIGIT-1:0]),
    .b    (car_q[DIGIT-1:0]),
    .cin  (cy_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  assign out_result = res_q;

  // Control FSM with registered handshakes; datapath advances one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_q     <= '0;
      car_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q    <= in_sum;
            car_q    <= in_carry;
            res_q    <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          res_q[int'(cnt_q) * DIGIT +: DIGIT] <= dig_s;
          cy_q  <= dig_cout;
          sum_q <= sum_q >> DIGIT;
          car_q <= car_q >> DIGIT;
          if (cnt_q == CW'(N - 1)) begin
            res_q[W]  <= dig_cout;
            cnt_q     <= '0;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Scoreboard bench for csa_resolve_serial at DIGIT = 2 (directed + random), 1 and 8 (random).
module tb_csa_resolve_serial;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [W-1:0] isum [3];
  logic [W-1:0] icar [3];
  logic [W:0]   ores [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned DG = (k == 0) ? 2 : ((k == 1) ? 1 : 8);
    csa_resolve_serial #(.W(W), .DIGIT(DG)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv[k]),
      .in_ready   (ir[k]),
      .in_sum     (isum[k]),
      .in_carry   (icar[k]),
      .out_valid  (ov[k]),
      .out_ready  (ordy[k]),
      .out_result (ores[k])
    );
  end

  int vectors     = 0;
  int miscompares = 0;
  logic [W:0] q0[$];
  logic [W:0] q1[$];
  logic [W:0] q2[$];
  bit drv_done [3];

  // Reference: plain unsigned addition, widened to hold the final carry.
  function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return RW'(s) + RW'(c);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int k, input logic [W:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_check(input int k);
    logic [W:0] e;
    if (qsize(k) == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL dup_out_%0d: got %0h expected none", k, ores[k]);
    end else begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("result_%0d", k), 32'(ores[k]), 32'(e));
    end
  endtask

  // Monitor: record accepted operands, compare each delivered result in order.
  task automatic mon_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          if (iv[k] && ir[k]) push(k, model(isum[k], icar[k]));
          if (ov[k] && ordy[k]) pop_check(k);
        end
      end
    end
  endtask

  // Offer one operand pair on instance 0 and hold it until accepted.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    int t;
    isum[0] = s;
    icar[0] = c;
    iv[0]   = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!ir[0] && t < 100);
    if (!ir[0]) fail_timeout("send_accept");
    #1 iv[0] = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (!ov[0] && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!ov[0]) fail_timeout("wait_out_valid");
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic rand_drive(input int k, input int nops);
    for (int i = 0; i < nops; i++) begin
      int t;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      isum[k] = rand_operand();
      icar[k] = rand_operand();
      iv[k]   = 1'b1;
      t = 0;
      do begin
        @(posedge clk);
        t++;
      end while (!ir[k] && t < 200);
      if (!ir[k]) fail_timeout($sformatf("rand_accept_%0d", k));
      #1 iv[k] = 1'b0;
    end
  endtask

  task automatic rand_ready(input int k);
    while (!drv_done[k]) begin
      @(posedge clk);
      #1 ordy[k] = 1'($urandom_range(0, 1));
    end
    ordy[k] = 1'b1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; isum[k] = '0; icar[k] = '0; drv_done[k] = 1'b0;
    end
    fork
      mon_loop();
    join_none

    // Reset values
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid_%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_out_result_%0d", k), 32'(ores[k]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1 ordy[0] = 1'b1;

    // 1: simple add, latency of N=4 cycles after the accept edge
    send(8'h0A, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1 check($sformatf("t1_latency_c%0d", i), 32'(ov[0]), (i == 4) ? 32'd1 : 32'd0);
    end
    check("t1_result", 32'(ores[0]), 32'd10);
    @(posedge clk);
    #1;
    check("t1_in_ready_back", 32'(ir[0]), 32'd1);
    check("t1_out_valid_drop", 32'(ov[0]), 32'd0);

    // 2: full carry ripple and maximum sum
    send(8'hFF, 8'h01);
    wait_out();
    check("t2_ripple", 32'(ores[0]), 32'h100);
    @(posedge clk);
    #1;
    send(8'hFF, 8'hFF);
    wait_out();
    check("t2_max", 32'(ores[0]), 32'h1FE);
    @(posedge clk);
    #1;

    // 3: backpressure holds the result; new offers ignored
    ordy[0] = 1'b0;
    send(8'h33, 8'h44);
    wait_out();
    isum[0] = 8'h55;
    icar[0] = 8'h11;
    iv[0]   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("t3_hold_valid", 32'(ov[0]), 32'd1);
      check("t3_hold_result", 32'(ores[0]), 32'h77);
      check("t3_in_ready_low", 32'(ir[0]), 32'd0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t3_release_valid", 32'(ov[0]), 32'd0);
    check("t3_release_ready", 32'(ir[0]), 32'd1);

    // 4: back-to-back with in_valid held; second accept N+2 edges after the first
    isum[0] = 8'd4;
    icar[0] = 8'd6;
    iv[0]   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ir[0] && n < 100);
    #1;
    isum[0] = 8'd11;
    icar[0] = 8'd7;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ir[0] && n < 100);
    #1 iv[0] = 1'b0;
    check("t4_accept_gap", 32'(n), 32'd6);
    wait_out();
    check("t4_second", 32'(ores[0]), 32'd18);
    @(posedge clk);
    #1;

    // 5: reset in the middle of RUN discards the operation
    send(8'd5, 8'd9);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    check("t5_rst_valid", 32'(ov[0]), 32'd0);
    check("t5_rst_result", 32'(ores[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("t5_no_partial", 32'(ov[0]), 32'd0);
    end
    check("t5_in_ready", 32'(ir[0]), 32'd1);
    send(8'd12, 8'd10);
    wait_out();
    check("t5_after_reset", 32'(ores[0]), 32'd22);
    @(posedge clk);
    #1;

    // 6: random traffic on all three digit widths
    fork
      begin rand_drive(0, 334); drv_done[0] = 1'b1; end
      begin rand_drive(1, 333); drv_done[1] = 1'b1; end
      begin rand_drive(2, 333); drv_done[2] = 1'b1; end
      rand_ready(0);
      rand_ready(1);
      rand_ready(2);
    join
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) check($sformatf("drop_%0d", k), 32'(qsize(k)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
